mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the single unified 16-bit instruction/data memory port between the fetch stage (instruction reads) and the MEM stage (loads/stores) of the 5-stage pipeline.
- Serialises requests and drives a ready/req handshake to the backing memory or cache.
- Returns per-requester ack/data, which the pipeline control turns into IF and MEM stalls.
- Gated by the CPU run state: no new grants while the CPU is idle.

Parameters:
- MAX_D_RUN, 4: consecutive data grants allowed while an instruction request waits; next grant then goes to instruction.
- AW, 8: address width (matches 8-bit pc).
- DW, 16: data width.

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- state  in  1  CPU run state: 1 = exec, 0 = idle
- i_req  in  1  fetch read request; held with i_addr stable until i_ack
- i_addr  in  AW  fetch address (pc)
- i_ack  out  1  one-cycle pulse: i_rdata valid
- i_rdata  out  DW  fetched instruction word
- d_req  in  1  data request; held with d_we/d_addr/d_wdata stable until d_ack
- d_we  in  1  1 = store, 0 = load
- d_addr  in  AW  data address
- d_wdata  in  DW  store data
- d_ack  out  1  one-cycle pulse: access complete; d_rdata valid for loads
- d_rdata  out  DW  load data
- m_req  out  1  memory request, held until m_ready
- m_we  out  1  memory write enable
- m_addr  out  AW  memory address
- m_wdata  out  DW  memory write data
- m_rdata  in  DW  memory read data, valid when m_ready=1
- m_ready  in  1  memory completes the current access this cycle
- busy  out  1  state != S_IDLE

Behaviour:
- Reset (reset=0, async): FSM = S_IDLE. All outputs are 0, including m_req, acks, rdata and busy. The starvation counter is 0. An in-flight memory access is abandoned; m_req drops immediately.
- FSM states:
  - S_IDLE: arbitrate.
  - S_GNT_I / S_GNT_D: m_req=1, memory outputs driven from registered request.
  - S_ACK: pulse the granted ack, then return to S_IDLE.
- Arbitration in S_IDLE, only when state=1:
  - d_req=1 and (i_req=0 or d_run_cnt<MAX_D_RUN) -> S_GNT_D.
  - Else if i_req=1 -> S_GNT_I.
  - Else stay in S_IDLE.
- Grant capture: address, we and wdata are latched into registers on the S_IDLE->S_GNT_* edge. m_* outputs come only from these registers; they must not change while m_req=1.
- d_run_cnt:
  - Increments, saturating at MAX_D_RUN, on each data grant made while i_req=1.
  - Clears on any instruction grant, or when i_req=0 at a data grant.
- Completion: in S_GNT_*, when m_ready=1:
  - Capture m_rdata into i_rdata or d_rdata; stores leave d_rdata unchanged.
  - Next state S_ACK.
  - In S_ACK, exactly one of i_ack/d_ack is 1 for one cycle; m_req=0.
- Latency:
  - Request seen in S_IDLE at cycle t -> m_req from t+1.
  - m_ready at cycle t+1+k -> ack at t+2+k.
  - Minimum 2 cycles (k=0); next grant evaluated at t+3+k.
- i_rdata/d_rdata hold their value until the next completed read of that requester.
- state falling to 0 mid-transaction: the in-flight access completes and acks normally; no new grant until state=1.
- A requester dropping req before its ack is a protocol violation. The arbiter still completes the latched access and pulses the ack.
- Simultaneous d_req and i_req at reset release: the first grant is data (counter=0).
- m_ready while m_req=0 is ignored.

Decomposition:
- Shared package:
  - exec/idle run-state constants.
  - FSM state encodings S_IDLE, S_GNT_I, S_GNT_D, S_ACK (2 bits).
  - AW/DW defaults.
- One natural sub-module, mem_arb_pick: combinational priority/starvation decision from d_req, i_req, d_run_cnt and state, producing grant_i and grant_d.

Test Plan:
- Single fetch: state=1, i_req=1, i_addr=0x05, memory returns 0x4A21 with k=0 -> m_req/m_addr=0x05 one cycle after request, i_ack=1 with i_rdata=0x4A21 two cycles after request, busy 0 afterwards.
- Load vs fetch collision: i_req and d_req rise together, d_addr=0x80, m_rdata=0x1234, k=2 -> data granted first, d_ack with d_rdata=0x1234 at t+4; instruction granted next at t+5.
- Starvation bound: d_req held high with back-to-back stores and i_req held, MAX_D_RUN=4 -> exactly 4 d_acks, then an i_ack before the 5th data grant; d_run_cnt then returns to 0.
- Store: d_we=1, d_addr=0x10, d_wdata=0xBEEF, k=3 -> m_we=1, m_wdata=0xBEEF stable for 4 cycles, d_ack once, d_rdata unchanged.
- Idle gating: state=0 with i_req=1 -> no m_req. An in-flight grant with state dropped mid-wait still produces its ack. A new grant happens only after state=1.
- Reset mid-access: reset=0 while m_req=1 -> m_req, busy and acks go 0 immediately without waiting for a clock edge. After release, a pending i_req is served fresh.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the unified memory-port arbiter: run-state
// constants, FSM encodings and default bus widths.
package mem_port_arbiter_pkg;

    localparam logic RUN_EXEC = 1'b1;
    localparam logic RUN_IDLE = 1'b0;

    localparam int AW_DEF = 8;
    localparam int DW_DEF = 16;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GNT_I = 2'd1,
        S_GNT_D = 2'd2,
        S_ACK   = 2'd3
    } arb_state_t;

endpackage

// File: rtl/mem_port_arbiter_pick.sv
// Combinational grant decision: data wins unless it has already taken
// MAX_D_RUN grants in a row while a fetch was waiting.
module mem_arb_pick
    import mem_port_arbiter_pkg::*;
#(
    parameter int MAX_D_RUN = 4,
    parameter int CW        = 3
) (
    input  logic          state,
    input  logic          i_req,
    input  logic          d_req,
    input  logic [CW-1:0] d_run_cnt,
    output logic          grant_i,
    output logic          grant_d
);

    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_D_RUN);

    logic run_en;

    assign run_en  = (state == RUN_EXEC);
    assign grant_d = run_en && d_req && (!i_req || (d_run_cnt < MAX_CNT));
    assign grant_i = run_en && i_req && !grant_d;

endmodule

// File: rtl/mem_port_arbiter.sv
// Serialises fetch and load/store accesses onto the single unified memory
// port; requests are latched at grant so the memory side never sees them move.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int MAX_D_RUN = 4,
    parameter int AW        = AW_DEF,
    parameter int DW        = DW_DEF
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          state,
    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    output logic          i_ack,
    output logic [DW-1:0] i_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_ack,
    output logic [DW-1:0] d_rdata,
    output logic          m_req,
    output logic          m_we,
    output logic [AW-1:0] m_addr,
    output logic [DW-1:0] m_wdata,
    input  logic [DW-1:0] m_rdata,
    input  logic          m_ready,
    output logic          busy
);

    localparam int            CW      = $clog2(MAX_D_RUN + 1);
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_D_RUN);

    arb_state_t    st, st_nxt;
    logic          grant_i, grant_d;
    logic          arb_en;
    logic [CW-1:0] d_run_cnt;
    logic          gnt_is_d_p0;
    logic          we_p0;
    logic [AW-1:0] addr_p0;
    logic [DW-1:0] wdata_p0;
    logic [DW-1:0] i_rdata_p1;
    logic [DW-1:0] d_rdata_p1;

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (v == MAX_CNT) ? v : v + 1'b1;
    endfunction

    mem_arb_pick #(
        .MAX_D_RUN (MAX_D_RUN),
        .CW        (CW)
    ) u_pick (
        .state     (state),
        .i_req     (i_req),
        .d_req     (d_req),
        .d_run_cnt (d_run_cnt),
        .grant_i   (grant_i),
        .grant_d   (grant_d)
    );

    assign arb_en = (st == S_IDLE);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) st <= S_IDLE;
        else        st <= st_nxt;
    end

    always_comb begin
        st_nxt = st;
        m_req  = 1'b0;
        i_ack  = 1'b0;
        d_ack  = 1'b0;
        busy   = 1'b1;
        case (st)
            S_IDLE: begin
                busy = 1'b0;
                if (grant_d)      st_nxt = S_GNT_D;
                else if (grant_i) st_nxt = S_GNT_I;
            end
            S_GNT_I, S_GNT_D: begin
                m_req = 1'b1;
                if (m_ready) st_nxt = S_ACK;
            end
            S_ACK: begin
                i_ack  = !gnt_is_d_p0;
                d_ack  = gnt_is_d_p0;
                st_nxt = S_IDLE;
            end
            default: st_nxt = S_IDLE;
        endcase
    end

    // Grant capture stage: request fields frozen for the whole memory access
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            gnt_is_d_p0 <= 1'b0;
            we_p0       <= 1'b0;
            addr_p0     <= '0;
            wdata_p0    <= '0;
            d_run_cnt   <= '0;
        end else if (arb_en && grant_d) begin
            gnt_is_d_p0 <= 1'b1;
            we_p0       <= d_we;
            addr_p0     <= d_addr;
            wdata_p0    <= d_wdata;
            d_run_cnt   <= i_req ? sat_inc(d_run_cnt) : '0;
        end else if (arb_en && grant_i) begin
            gnt_is_d_p0 <= 1'b0;
            we_p0       <= 1'b0;
            addr_p0     <= i_addr;
            wdata_p0    <= '0;
            d_run_cnt   <= '0;
        end
    end

    // Completion stage: read data held until that requester's next read
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            i_rdata_p1 <= '0;
            d_rdata_p1 <= '0;
        end else if (m_ready) begin
            if (st == S_GNT_I)              i_rdata_p1 <= m_rdata;
            if (st == S_GNT_D && !we_p0)    d_rdata_p1 <= m_rdata;
        end
    end

    assign m_we    = we_p0;
    assign m_addr  = addr_p0;
    assign m_wdata = wdata_p0;
    assign i_rdata = i_rdata_p1;
    assign d_rdata = d_rdata_p1;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: transaction-level model compared every
// cycle, plus hand-computed expectations at the key points of each scenario.
module tb_mem_port_arbiter;

    localparam int MAXD = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        state = 1'b0;
    logic        i_req = 1'b0;
    logic [7:0]  i_addr = '0;
    logic        i_ack;
    logic [15:0] i_rdata;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [7:0]  d_addr = '0;
    logic [15:0] d_wdata = '0;
    logic        d_ack;
    logic [15:0] d_rdata;
    logic        m_req;
    logic        m_we;
    logic [7:0]  m_addr;
    logic [15:0] m_wdata;
    logic [15:0] m_rdata = 16'hDEAD;
    logic        m_ready = 1'b0;
    logic        busy;

    int checks = 0;
    int failures = 0;

    // memory responder / requester controls
    logic [15:0] mem [256];
    int  lat = 0;
    int  wcnt = 0;
    bit  stray = 1'b0;
    bit  i_hold = 1'b0;
    bit  d_hold = 1'b0;

    mem_port_arbiter #(.MAX_D_RUN(MAXD), .AW(8), .DW(16)) dut (
        .clock   (clock),
        .reset   (reset),
        .state   (state),
        .i_req   (i_req),
        .i_addr  (i_addr),
        .i_ack   (i_ack),
        .i_rdata (i_rdata),
        .d_req   (d_req),
        .d_we    (d_we),
        .d_addr  (d_addr),
        .d_wdata (d_wdata),
        .d_ack   (d_ack),
        .d_rdata (d_rdata),
        .m_req   (m_req),
        .m_we    (m_we),
        .m_addr  (m_addr),
        .m_wdata (m_wdata),
        .m_rdata (m_rdata),
        .m_ready (m_ready),
        .busy    (busy)
    );

    always #5 clock = ~clock;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h at %0t", nm, got, exp, $time);
        end
    endtask

    // Reference model: one outstanding transaction, one ack cycle after it
    bit          md_txn, md_ackc, md_isd, md_we;
    logic [7:0]  md_addr;
    logic [15:0] md_wdata, md_ird, md_drd;
    int          md_run;

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            md_txn <= 0; md_ackc <= 0; md_isd <= 0; md_we <= 0;
            md_addr <= '0; md_wdata <= '0; md_ird <= '0; md_drd <= '0; md_run <= 0;
        end else if (md_ackc) begin
            md_ackc <= 0;
        end else if (md_txn) begin
            if (m_ready) begin
                if (!md_isd)    md_ird <= m_rdata;
                else if (!md_we) md_drd <= m_rdata;
                md_txn  <= 0;
                md_ackc <= 1;
            end
        end else if (state) begin
            if (d_req && (!i_req || md_run < MAXD)) begin
                md_txn <= 1; md_isd <= 1; md_we <= d_we;
                md_addr <= d_addr; md_wdata <= d_wdata;
                md_run <= i_req ? ((md_run < MAXD) ? md_run + 1 : MAXD) : 0;
            end else if (i_req) begin
                md_txn <= 1; md_isd <= 0; md_we <= 0;
                md_addr <= i_addr; md_run <= 0;
            end
        end
    end

    always @(posedge clock) begin
        #1;
        chk("m_req", m_req, md_txn);
        chk("busy", busy, md_txn | md_ackc);
        chk("i_ack", i_ack, md_ackc & !md_isd);
        chk("d_ack", d_ack, md_ackc & md_isd);
        chk("i_rdata", i_rdata, md_ird);
        chk("d_rdata", d_rdata, md_drd);
        if (md_txn) begin
            chk("m_addr", m_addr, md_addr);
            chk("m_we", m_we, md_we);
            if (md_isd) chk("m_wdata", m_wdata, md_wdata);
        end
    end

    // One cycle: memory responder and requester ack-drop at the falling edge
    task automatic cyc();
        @(negedge clock);
        if (m_req) begin
            if (wcnt == lat) begin
                m_ready = 1'b1;
                m_rdata = mem[m_addr];
                if (m_we) mem[m_addr] = m_wdata;
            end else begin
                m_ready = 1'b0;
                m_rdata = 16'hDEAD;
                wcnt++;
            end
        end else begin
            m_ready = stray;
            m_rdata = 16'hDEAD;
            wcnt = 0;
        end
        if (i_ack && !i_hold) i_req = 1'b0;
        if (d_ack && !d_hold) d_req = 1'b0;
    endtask

    task automatic wait_i_ack(input int budget);
        bit seen;
        seen = 0;
        for (int c = 0; c < budget && !seen; c++) begin
            cyc();
            if (i_ack) seen = 1;
        end
        chk("i_ack_within_budget", seen, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int nd;
        bit got_i;
        for (int a = 0; a < 256; a++) mem[a] = 16'(a * 16'h0101) ^ 16'h5A5A;
        mem[8'h05] = 16'h4A21;
        mem[8'h80] = 16'h1234;
        mem[8'h20] = 16'h7E01;
        mem[8'h21] = 16'h2222;
        mem[8'h33] = 16'h3333;
        mem[8'h34] = 16'h3434;
        mem[8'h40] = 16'h4040;

        // reset state
        cyc(); cyc();
        chk("rst_m_req", m_req, 0);
        chk("rst_busy", busy, 0);
        chk("rst_acks", {i_ack, d_ack}, 0);
        chk("rst_rdata", {i_rdata, d_rdata}, 0);
        chk("rst_m_bus", {m_we, m_addr, m_wdata}, 0);
        reset = 1'b1;
        cyc();

        // single fetch, k=0
        lat = 0; state = 1'b1; i_addr = 8'h05; i_req = 1'b1;
        cyc();
        chk("f1_m_req", m_req, 1);
        chk("f1_m_addr", m_addr, 8'h05);
        cyc();
        chk("f1_i_ack", i_ack, 1);
        chk("f1_i_rdata", i_rdata, 16'h4A21);
        cyc();
        chk("f1_busy_after", busy, 0);
        chk("f1_i_ack_after", i_ack, 0);

        // load vs fetch collision, k=2
        lat = 2; i_addr = 8'h20; d_addr = 8'h80; d_we = 1'b0;
        i_req = 1'b1; d_req = 1'b1;
        cyc();
        chk("c_m_addr_data_first", m_addr, 8'h80);
        chk("c_m_we", m_we, 0);
        cyc(); cyc();
        chk("c_d_ack_early", d_ack, 0);
        cyc();
        chk("c_d_ack", d_ack, 1);
        chk("c_d_rdata", d_rdata, 16'h1234);
        cyc();
        chk("c_arbitrate_gap", busy, 0);
        cyc();
        chk("c_i_grant", m_req, 1);
        chk("c_i_addr", m_addr, 8'h20);
        wait_i_ack(10);
        chk("c_i_rdata", i_rdata, 16'h7E01);
        cyc();

        // starvation bound: stores held against a waiting fetch, two rounds
        lat = 0; d_we = 1'b1; d_addr = 8'h30; d_wdata = 16'h1111;
        i_addr = 8'h21; d_hold = 1'b1; i_hold = 1'b1;
        i_req = 1'b1; d_req = 1'b1;
        for (int r = 0; r < 2; r++) begin
            nd = 0; got_i = 0;
            for (int c = 0; c < 60 && !got_i; c++) begin
                cyc();
                if (d_ack) nd++;
                if (i_ack) got_i = 1;
            end
            chk("starve_i_served", got_i, 1);
            chk("starve_d_acks", nd, MAXD);
        end
        chk("starve_i_rdata", i_rdata, 16'h2222);
        chk("starve_d_rdata_kept", d_rdata, 16'h1234);
        d_hold = 1'b0; i_hold = 1'b0; i_req = 1'b0; d_req = 1'b0;
        cyc(); cyc();

        // store, k=3
        lat = 3; d_we = 1'b1; d_addr = 8'h10; d_wdata = 16'hBEEF; d_req = 1'b1;
        for (int c = 0; c < 4; c++) begin
            cyc();
            chk("st_m_req", m_req, 1);
            chk("st_m_we", m_we, 1);
            chk("st_m_wdata", m_wdata, 16'hBEEF);
            chk("st_m_addr", m_addr, 8'h10);
        end
        cyc();
        chk("st_d_ack", d_ack, 1);
        chk("st_d_rdata_kept", d_rdata, 16'h1234);
        cyc();
        chk("st_d_ack_once", d_ack, 0);
        chk("st_mem_written", mem[8'h10], 16'hBEEF);

        // idle gating, with stray m_ready while no request is out
        state = 1'b0; lat = 3; i_addr = 8'h33; i_req = 1'b1; stray = 1'b1;
        for (int c = 0; c < 3; c++) begin
            cyc();
            chk("idle_no_m_req", m_req, 0);
            chk("idle_not_busy", busy, 0);
        end
        stray = 1'b0;
        state = 1'b1;
        cyc();
        chk("idle_grant_on_exec", m_req, 1);
        state = 1'b0;
        wait_i_ack(10);
        chk("idle_inflight_rdata", i_rdata, 16'h3333);
        i_addr = 8'h34; i_req = 1'b1;
        for (int c = 0; c < 3; c++) begin
            cyc();
            chk("idle_hold_off", m_req, 0);
        end
        state = 1'b1;
        cyc();
        chk("idle_resume_addr", m_addr, 8'h34);
        wait_i_ack(10);
        cyc();

        // asynchronous reset in the middle of an access
        lat = 5; i_addr = 8'h40; i_req = 1'b1;
        cyc();
        chk("ar_m_req_before", m_req, 1);
        #2 reset = 1'b0;
        #1;
        chk("ar_m_req_dropped", m_req, 0);
        chk("ar_busy_dropped", busy, 0);
        chk("ar_acks", {i_ack, d_ack}, 0);
        chk("ar_rdata_cleared", {i_rdata, d_rdata}, 0);
        cyc(); cyc();
        reset = 1'b1;
        cyc();
        chk("ar_fresh_grant", m_req, 1);
        chk("ar_fresh_addr", m_addr, 8'h40);
        wait_i_ack(20);
        chk("ar_fresh_rdata", i_rdata, 16'h4040);
        cyc(); cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
